// File: rtl/cpu_arb_pkg.sv
// Shared types for the CPU instruction/data memory arbiter: FSM states,
// port identifiers and the captured request record.
package cpu_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        BUSY_I = 2'd1,
        BUSY_D = 2'd2
    } arb_state_t;

    localparam int PORT_I = 0;
    localparam int PORT_D = 1;

    typedef struct packed {
        logic [31:0] addr;
        logic        write;
        logic [3:0]  byte_enable;
        logic [31:0] wdata;
    } arb_req_t;

endpackage

// File: rtl/cpu_arb_slot.sv
// One-deep pending-request slot: captures a request pulse, clears on grant,
// and flags (drop) a request arriving while the port is still occupied.
module cpu_arb_slot
    import cpu_arb_pkg::*;
(
    input  logic     clock,
    input  logic     reset,
    input  logic     request,
    input  arb_req_t req_in,
    input  logic     busy,
    input  logic     grant,
    output logic     cand,
    output arb_req_t cand_req
);

    logic     pending_reg;
    arb_req_t req_reg;
    logic     drop;
    logic     accept;

    // busy is low in the completion cycle, so a new request may follow an ack directly
    assign drop     = request & (pending_reg | busy);
    assign accept   = request & ~drop;
    assign cand     = pending_reg | accept;
    assign cand_req = pending_reg ? req_reg : req_in;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pending_reg <= 1'b0;
            req_reg     <= '0;
        end else begin
            if (grant) begin
                pending_reg <= 1'b0;
            end else if (accept) begin
                pending_reg <= 1'b1;
            end
            if (accept) begin
                req_reg <= req_in;
            end
        end
    end

endmodule

// File: rtl/cpu_mem_arbiter.sv
// Arbitrates the CPU instruction and data buses onto one request/ack memory port.
// Define CPU_ARB_STATS_EN to add the stat_conflicts / stat_stall counters.
module cpu_mem_arbiter
    import cpu_arb_pkg::*;
#(
    parameter int ADDR_W   = 16,
    parameter int MAX_WAIT = 4
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              cpui_request,
    input  logic [31:0]       cpui_addr,
    output logic [31:0]       cpui_rdata,
    output logic              cpui_ack,
    input  logic              cpud_request,
    input  logic [ADDR_W-1:0] cpud_addr,
    input  logic              cpud_write,
    input  logic [3:0]        cpud_byte_enable,
    input  logic [31:0]       cpud_wdata,
    output logic [31:0]       cpud_rdata,
    output logic              cpud_ack,
    output logic              mem_request,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_write,
    output logic [3:0]        mem_byte_enable,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack
`ifdef CPU_ARB_STATS_EN
    ,
    output logic [31:0]       stat_conflicts,
    output logic [31:0]       stat_stall
`endif
);

    arb_state_t        state_reg, state_next;
    logic [3:0]        wait_cnt_reg, wait_cnt_next;
    logic              mem_request_reg;
    logic [ADDR_W-1:0] mem_addr_reg;
    logic              mem_write_reg;
    logic [3:0]        mem_byte_enable_reg;
    logic [31:0]       mem_wdata_reg;
    logic              cpui_ack_reg, cpud_ack_reg;
    logic [31:0]       cpui_rdata_reg, cpud_rdata_reg;

    arb_req_t req_in_i, req_in_d, cand_req_i, cand_req_d, sel_req;
    logic     cand_i, cand_d, busy_i, busy_d;
    logic     arb_en, pick_i, grant_i, grant_d;
    logic     sel_port, ack_i, ack_d;

    assign req_in_i = '{addr: cpui_addr, write: 1'b0, byte_enable: 4'hf, wdata: 32'h0};
    assign req_in_d = '{addr: 32'(cpud_addr), write: cpud_write,
                        byte_enable: cpud_byte_enable, wdata: cpud_wdata};

    assign busy_i = (state_reg == BUSY_I) & ~mem_ack;
    assign busy_d = (state_reg == BUSY_D) & ~mem_ack;

    cpu_arb_slot u_slot_i (
        .clock    (clock),
        .reset    (reset),
        .request  (cpui_request),
        .req_in   (req_in_i),
        .busy     (busy_i),
        .grant    (grant_i),
        .cand     (cand_i),
        .cand_req (cand_req_i)
    );

    cpu_arb_slot u_slot_d (
        .clock    (clock),
        .reset    (reset),
        .request  (cpud_request),
        .req_in   (req_in_d),
        .busy     (busy_d),
        .grant    (grant_d),
        .cand     (cand_d),
        .cand_req (cand_req_d)
    );

    // A new grant may be made from IDLE or in the cycle the current transfer completes
    assign arb_en   = (state_reg == IDLE) | mem_ack;
    assign pick_i   = cand_i & (~cand_d | (wait_cnt_reg >= 4'(MAX_WAIT)));
    assign grant_i  = arb_en & pick_i;
    assign grant_d  = arb_en & cand_d & ~pick_i;
    assign sel_port = grant_d ? 1'(PORT_D) : 1'(PORT_I);
    assign sel_req  = (sel_port == 1'(PORT_D)) ? cand_req_d : cand_req_i;
    assign ack_i    = (state_reg == BUSY_I) & mem_ack;
    assign ack_d    = (state_reg == BUSY_D) & mem_ack;

    generate
        if (ADDR_W < 32) begin : g_addr_hi
            // instruction address bits above ADDR_W are discarded by design
            logic addr_hi_unused;
            assign addr_hi_unused = ^sel_req.addr[31:ADDR_W];
        end
    endgenerate

    always_comb begin
        state_next    = state_reg;
        wait_cnt_next = wait_cnt_reg;
        case (state_reg)
            IDLE: begin
                if (grant_i) begin
                    state_next = BUSY_I;
                end else if (grant_d) begin
                    state_next = BUSY_D;
                end
            end
            BUSY_I, BUSY_D: begin
                if (mem_ack) begin
                    if (grant_i) begin
                        state_next = BUSY_I;
                    end else if (grant_d) begin
                        state_next = BUSY_D;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        if (!cand_i || grant_i) begin
            wait_cnt_next = '0;
        end else if (grant_d && wait_cnt_reg != 4'hf) begin
            wait_cnt_next = wait_cnt_reg + 4'd1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_reg           <= IDLE;
            wait_cnt_reg        <= '0;
            mem_request_reg     <= 1'b0;
            mem_addr_reg        <= '0;
            mem_write_reg       <= 1'b0;
            mem_byte_enable_reg <= '0;
            mem_wdata_reg       <= '0;
            cpui_ack_reg        <= 1'b0;
            cpui_rdata_reg      <= '0;
            cpud_ack_reg        <= 1'b0;
            cpud_rdata_reg      <= '0;
        end else begin
            state_reg       <= state_next;
            wait_cnt_reg    <= wait_cnt_next;
            mem_request_reg <= grant_i | grant_d;
            // mem_* fields stay put for the whole transfer; mem_write tells a write ack apart
            if (grant_i | grant_d) begin
                mem_addr_reg        <= sel_req.addr[ADDR_W-1:0];
                mem_write_reg       <= sel_req.write;
                mem_byte_enable_reg <= sel_req.byte_enable;
                mem_wdata_reg       <= sel_req.wdata;
            end
            cpui_ack_reg   <= ack_i;
            cpui_rdata_reg <= ack_i ? mem_rdata : 32'h0;
            cpud_ack_reg   <= ack_d;
            cpud_rdata_reg <= (ack_d && !mem_write_reg) ? mem_rdata : 32'h0;
        end
    end

    assign mem_request     = mem_request_reg;
    assign mem_addr        = mem_addr_reg;
    assign mem_write       = mem_write_reg;
    assign mem_byte_enable = mem_byte_enable_reg;
    assign mem_wdata       = mem_wdata_reg;
    assign cpui_ack        = cpui_ack_reg;
    assign cpui_rdata      = cpui_rdata_reg;
    assign cpud_ack        = cpud_ack_reg;
    assign cpud_rdata      = cpud_rdata_reg;

`ifdef CPU_ARB_STATS_EN
    logic [31:0] stat_conflicts_reg, stat_stall_reg;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            stat_conflicts_reg <= '0;
            stat_stall_reg     <= '0;
        end else begin
            if ((grant_i | grant_d) && cand_i && cand_d) begin
                stat_conflicts_reg <= stat_conflicts_reg + 32'd1;
            end
            if ((cand_i && !grant_i) || (cand_d && !grant_d)) begin
                stat_stall_reg <= stat_stall_reg + 32'd1;
            end
        end
    end

    assign stat_conflicts = stat_conflicts_reg;
    assign stat_stall     = stat_stall_reg;
`endif

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed scenarios plus randomized
// traffic against a transaction-level model with its own memory array.
module tb_cpu_mem_arbiter;
    import cpu_arb_pkg::*;

    localparam int ADDR_W   = 16;
    localparam int MAX_WAIT = 4;

    logic        clock = 1'b0;
    logic        reset;
    logic        cpui_request;
    logic [31:0] cpui_addr;
    logic [31:0] cpui_rdata;
    logic        cpui_ack;
    logic        cpud_request;
    logic [15:0] cpud_addr;
    logic        cpud_write;
    logic [3:0]  cpud_byte_enable;
    logic [31:0] cpud_wdata;
    logic [31:0] cpud_rdata;
    logic        cpud_ack;
    logic        mem_request;
    logic [15:0] mem_addr;
    logic        mem_write;
    logic [3:0]  mem_byte_enable;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;
`ifdef CPU_ARB_STATS_EN
    logic [31:0] stat_conflicts;
    logic [31:0] stat_stall;
`endif

    always #5 clock = ~clock;

    cpu_mem_arbiter #(.ADDR_W(ADDR_W), .MAX_WAIT(MAX_WAIT)) dut (
        .clock            (clock),
        .reset            (reset),
        .cpui_request     (cpui_request),
        .cpui_addr        (cpui_addr),
        .cpui_rdata       (cpui_rdata),
        .cpui_ack         (cpui_ack),
        .cpud_request     (cpud_request),
        .cpud_addr        (cpud_addr),
        .cpud_write       (cpud_write),
        .cpud_byte_enable (cpud_byte_enable),
        .cpud_wdata       (cpud_wdata),
        .cpud_rdata       (cpud_rdata),
        .cpud_ack         (cpud_ack),
        .mem_request      (mem_request),
        .mem_addr         (mem_addr),
        .mem_write        (mem_write),
        .mem_byte_enable  (mem_byte_enable),
        .mem_wdata        (mem_wdata),
        .mem_rdata        (mem_rdata),
        .mem_ack          (mem_ack)
`ifdef CPU_ARB_STATS_EN
        ,
        .stat_conflicts   (stat_conflicts),
        .stat_stall       (stat_stall)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // model state
    logic [31:0] mem_model [0:16383];
    int          cyc = 0;
    bit          out_i, out_d, iss_i, iss_d;
    logic [15:0] rec_i_addr, rec_d_addr;
    logic        rec_d_write;
    logic [3:0]  rec_d_be;
    logic [31:0] rec_d_wdata;
    int          inflight = -1;
    int          lat = 0;
    int          fixed_lat = 0;
    bit          auto_d = 0;
    bit          exp_ack_i, exp_ack_d, exp_req;
    logic [31:0] exp_rd_i, exp_rd_d;
    int          consec = 0;
    int          drops_model = 0;
    int          drops_dut = 0;
    int          n_grants = 0;
    int          ack_cyc_i, ack_cyc_d;
    logic [31:0] last_rd_i, last_rd_d;
    logic        last_write;
    logic [3:0]  last_be;
    logic [31:0] last_wdata;
    int          grant_q[$];
    logic [15:0] grant_addr_q[$];

    always @(posedge clock) begin
        if (reset && dut.u_slot_i.drop) begin
            drops_dut++;
            $display("protocol error: instruction request dropped (cycle %0d)", cyc);
        end
        if (reset && dut.u_slot_d.drop) begin
            drops_dut++;
            $display("protocol error: data request dropped (cycle %0d)", cyc);
        end
    end

    task automatic step(input bit ri, input logic [31:0] ai, input bit rd, input logic [15:0] ad,
                        input bit wd, input logic [3:0] bd, input logic [31:0] dd);
        int port;
        bit ui, ud, just_granted;
        @(negedge clock);
        cyc++;
        check_eq("cpui_ack", cpui_ack, exp_ack_i);
        check_eq("cpui_rdata", cpui_rdata, exp_ack_i ? exp_rd_i : 32'h0);
        check_eq("cpud_ack", cpud_ack, exp_ack_d);
        check_eq("cpud_rdata", cpud_rdata, exp_ack_d ? exp_rd_d : 32'h0);
        if (cpui_ack) begin
            ack_cyc_i = cyc;
            last_rd_i = cpui_rdata;
            $display("txn I  ack cyc=%0d addr=%04h rdata=%08h", cyc, rec_i_addr, cpui_rdata);
        end
        if (cpud_ack) begin
            ack_cyc_d = cyc;
            last_rd_d = cpud_rdata;
            $display("txn D  ack cyc=%0d addr=%04h write=%0d rdata=%08h", cyc, rec_d_addr, rec_d_write, cpud_rdata);
        end
        exp_ack_i = 0;
        exp_ack_d = 0;
        check_eq("mem_request", mem_request, exp_req);
        just_granted = 0;
        ui = out_i && !iss_i;
        ud = out_d && !iss_d;
        if (mem_request && (ui || ud)) begin
            if (ui && ud) port = (consec >= MAX_WAIT) ? PORT_I : PORT_D;
            else          port = ui ? PORT_I : PORT_D;
            if (port == PORT_I) begin
                check_eq("grant_i_addr", mem_addr, rec_i_addr);
                check_eq("grant_i_write", mem_write, 1'b0);
                check_eq("grant_i_be", mem_byte_enable, 4'hf);
                iss_i  = 1;
                consec = 0;
            end else begin
                check_eq("grant_d_addr", mem_addr, rec_d_addr);
                check_eq("grant_d_write", mem_write, rec_d_write);
                check_eq("grant_d_be", mem_byte_enable, rec_d_be);
                check_eq("grant_d_wdata", mem_wdata, rec_d_wdata);
                iss_d  = 1;
                consec = ui ? consec + 1 : 0;
                if (rec_d_write) begin
                    for (int b = 0; b < 4; b++)
                        if (rec_d_be[b]) mem_model[rec_d_addr[15:2]][8*b +: 8] = rec_d_wdata[8*b +: 8];
                end
            end
            last_write = mem_write;
            last_be    = mem_byte_enable;
            last_wdata = mem_wdata;
            inflight   = port;
            lat        = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 2));
            just_granted = 1;
            n_grants++;
            grant_q.push_back(port);
            grant_addr_q.push_back(mem_addr);
        end
        mem_ack   = 1'b0;
        mem_rdata = $urandom;
        if (inflight >= 0 && !just_granted) begin
            if (lat == 0) begin
                mem_ack = 1'b1;
                if (inflight == PORT_I) begin
                    mem_rdata = mem_model[rec_i_addr[15:2]];
                    exp_ack_i = 1;
                    exp_rd_i  = mem_rdata;
                    out_i = 0;
                    iss_i = 0;
                end else begin
                    if (!rec_d_write) mem_rdata = mem_model[rec_d_addr[15:2]];
                    exp_ack_d = 1;
                    exp_rd_d  = rec_d_write ? 32'h0 : mem_rdata;
                    out_d = 0;
                    iss_d = 0;
                    if (auto_d) begin
                        rd = 1;
                        ad = 16'h8000 | 16'($urandom & 32'h7ffc);
                        wd = 0;
                        bd = 4'hf;
                    end
                end
                inflight = -1;
            end else begin
                lat--;
            end
        end
        cpui_request     = ri;
        cpui_addr        = ai;
        cpud_request     = rd;
        cpud_addr        = ad;
        cpud_write       = wd;
        cpud_byte_enable = bd;
        cpud_wdata       = dd;
        if (ri) begin
            if (!out_i) begin
                out_i = 1; iss_i = 0; rec_i_addr = ai[15:0];
            end else drops_model++;
        end
        if (rd) begin
            if (!out_d) begin
                out_d = 1; iss_d = 0;
                rec_d_addr = ad; rec_d_write = wd; rec_d_be = bd; rec_d_wdata = dd;
            end else drops_model++;
        end
        exp_req = (inflight < 0) && ((out_i && !iss_i) || (out_d && !iss_d));
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) step(1'b0, 32'h0, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
    endtask

    initial begin
        int c0, g0, d0, nd;
        bit seen_i;
        logic [31:0] orig;
        for (int i = 0; i < 16384; i++) mem_model[i] = (i * 32'h01010101) ^ 32'ha5a50000;
        mem_model[4] = 32'hDEADBEEF;
        cpui_request = 0; cpui_addr = 0; cpud_request = 0; cpud_addr = 0;
        cpud_write = 0; cpud_byte_enable = 0; cpud_wdata = 0; mem_rdata = 0; mem_ack = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        repeat (2) @(negedge clock);
        check_eq("rst_mem_request", mem_request, 1'b0);
        check_eq("rst_mem_addr", mem_addr, 16'h0);
        check_eq("rst_mem_write", mem_write, 1'b0);
        check_eq("rst_mem_be", mem_byte_enable, 4'h0);
        check_eq("rst_cpui_ack", cpui_ack, 1'b0);
        check_eq("rst_cpud_ack", cpud_ack, 1'b0);
        check_eq("rst_rdata", {cpui_rdata, cpud_rdata}, 64'h0);
`ifdef CPU_ARB_STATS_EN
        check_eq("rst_stats", {stat_conflicts, stat_stall}, 64'h0);
`endif
        reset = 1'b1;

        // isolated instruction read, zero-wait memory
        fixed_lat = 0;
        step(1'b1, 32'h0000_0010, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
        c0 = cyc;
        idle(5);
        check_eq("iso_ack_latency", ack_cyc_i - c0, 3);
        check_eq("iso_rdata", last_rd_i, 32'hDEADBEEF);

        // simultaneous requests: data first, instruction back-to-back
        grant_addr_q.delete();
        step(1'b1, 32'h0000_0020, 1'b1, 16'h0040, 1'b0, 4'hf, 32'h0);
        c0 = cyc;
        idle(7);
        check_eq("sim_first_addr", grant_addr_q[0], 16'h0040);
        check_eq("sim_second_addr", grant_addr_q[1], 16'h0020);
        check_eq("sim_d_latency", ack_cyc_d - c0, 3);
        check_eq("sim_i_latency", ack_cyc_i - c0, 5);

        // starvation bound
        grant_q.delete();
        auto_d = 1;
        step(1'b1, 32'h0000_0060, 1'b1, 16'h8000, 1'b0, 4'hf, 32'h0);
        idle(14);
        auto_d = 0;
        idle(6);
        nd = 0;
        seen_i = 0;
        foreach (grant_q[k]) begin
            if (!seen_i) begin
                if (grant_q[k] == PORT_D) nd++;
                else seen_i = 1;
            end
        end
        check_eq("starve_d_grants", nd, MAX_WAIT);
        check_eq("starve_i_granted", seen_i, 1'b1);
        check_eq("starve_wait_cnt", dut.wait_cnt_reg, 4'd0);

        // data write, then read back through the memory
        orig = mem_model[16'h0100 >> 2];
        step(1'b0, 32'h0, 1'b1, 16'h0100, 1'b1, 4'b0011, 32'h12345678);
        idle(5);
        check_eq("wr_mem_write", last_write, 1'b1);
        check_eq("wr_mem_be", last_be, 4'b0011);
        check_eq("wr_mem_wdata", last_wdata, 32'h12345678);
        check_eq("wr_ack_rdata", last_rd_d, 32'h0);
        step(1'b0, 32'h0, 1'b1, 16'h0100, 1'b0, 4'hf, 32'h0);
        idle(5);
        check_eq("wr_readback", last_rd_d, {orig[31:16], 16'h5678});

        // slow memory: held state, dropped second request
        fixed_lat = 4;
        g0 = n_grants;
        d0 = drops_model;
        step(1'b1, 32'h0000_0030, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
        c0 = cyc;
        idle(2);
        step(1'b1, 32'h0000_0034, 1'b0, 16'h0, 1'b0, 4'h0, 32'h0);
        idle(6);
        check_eq("slow_grants", n_grants - g0, 1);
        check_eq("slow_drops", drops_model - d0, 1);
        check_eq("slow_ack_latency", ack_cyc_i - c0, 7);
        check_eq("slow_drop_flag", drops_dut, drops_model);

        // randomized traffic
        fixed_lat = -1;
        for (int k = 0; k < 600; k++) begin
            step(($urandom_range(0, 3) == 0), $urandom & 32'hffff_7ffc,
                 ($urandom_range(0, 3) == 0), 16'h8000 | 16'($urandom & 32'h7ffc),
                 1'($urandom), 4'($urandom), $urandom);
        end
        idle(10);
        check_eq("rand_drops", drops_dut, drops_model);

        // reset while a data read is in flight
        fixed_lat = 3;
        step(1'b0, 32'h0, 1'b1, 16'h0200, 1'b0, 4'hf, 32'h0);
        idle(2);
        @(negedge clock);
        reset = 1'b0;
        cpui_request = 0; cpud_request = 0; mem_ack = 0;
        #1;
        check_eq("rr_mem_request", mem_request, 1'b0);
        check_eq("rr_mem_addr", mem_addr, 16'h0);
        check_eq("rr_mem_be", mem_byte_enable, 4'h0);
        check_eq("rr_cpud_ack", cpud_ack, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        mem_ack = 1'b1;
        mem_rdata = 32'hBAD0BAD0;
        @(negedge clock);
        mem_ack = 1'b0;
        check_eq("rr_late_ack", cpud_ack, 1'b0);
        check_eq("rr_late_rdata", cpud_rdata, 32'h0);
        check_eq("rr_no_request", mem_request, 1'b0);
        out_i = 0; out_d = 0; iss_i = 0; iss_d = 0; inflight = -1;
        exp_ack_i = 0; exp_ack_d = 0; exp_req = 0; consec = 0;
        fixed_lat = 0;
        step(1'b0, 32'h0, 1'b1, 16'h0204, 1'b0, 4'hf, 32'h0);
        c0 = cyc;
        idle(5);
        check_eq("rr_after_latency", ack_cyc_d - c0, 3);
        check_eq("rr_after_rdata", last_rd_d, mem_model[16'h0204 >> 2]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/cpu_mem_arbiter.md
Name: cpu_mem_arbiter

Overview:
- Shares one single-port, request/ack program memory between the CPU instruction bus and CPU data bus.
- Captures the single-cycle request pulses from each bus and serialises them onto the memory port, one transaction in flight at a time.
- Routes each response back to the requester that issued it.
- Data port has priority over the instruction port, bounded by an anti-starvation limit.

Parameters:
- ADDR_W, 16, byte-address bits forwarded to memory (memory uses word index addr[ADDR_W-1:2]).
- MAX_WAIT, 4, consecutive data grants allowed while an instruction request waits; range 1..15.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- cpui_request  in  1  instruction read request, one-cycle pulse.
- cpui_addr  in  32  instruction byte address; bits [ADDR_W-1:0] used.
- cpui_rdata  out  32  instruction data, valid only while cpui_ack=1, else 0.
- cpui_ack  out  1  one-cycle instruction completion pulse.
- cpud_request  in  1  data request, one-cycle pulse.
- cpud_addr  in  ADDR_W  data byte address.
- cpud_write  in  1  1=write, 0=read.
- cpud_byte_enable  in  4  write byte lanes.
- cpud_wdata  in  32  write data.
- cpud_rdata  out  32  read data, valid while cpud_ack=1 for a read, else 0.
- cpud_ack  out  1  one-cycle data completion pulse (reads and writes).
- mem_request  out  1  one-cycle memory request pulse.
- mem_addr  out  ADDR_W  memory byte address.
- mem_write  out  1  memory write strobe.
- mem_byte_enable  out  4  memory byte lanes; 4'hf for instruction reads.
- mem_wdata  out  32  memory write data.
- mem_rdata  in  32  memory read data, sampled when mem_ack=1.
- mem_ack  in  1  memory completion pulse, any latency of 1 cycle or more after mem_request.

Behaviour:
- Reset (asynchronous, active low):
  - State goes to IDLE; both pending slots are cleared; the starvation counter is zeroed.
  - All outputs are 0.
  - A transaction in flight when reset asserts is abandoned; a late mem_ack is ignored in IDLE.
- Capture:
  - Each port has one pending slot. A request pulse latches address, write, byte_enable and wdata at the clock edge.
  - A request on a port whose slot is pending or in flight is dropped. Simulation prints a $display protocol error.
- State machine: IDLE, BUSY_I, BUSY_D.
  - Grant candidates are the pending slots OR'd with the current-cycle request (bypass). A request arriving in IDLE therefore issues mem_request on the next edge.
  - IDLE, with a candidate: register the mem_* fields and a mem_request pulse, then go to BUSY_I or BUSY_D.
  - BUSY_x, mem_ack=1: capture mem_rdata and pulse cpux_ack at the next edge.
    - In that same cycle, re-arbitrate. If a candidate exists, issue the next mem_request at that edge (back-to-back) and go to the new BUSY state; otherwise go to IDLE.
  - BUSY_x, mem_ack=0: hold the state; mem_request stays 0.
- Priority:
  - Data wins ties by default.
  - wait_cnt (4 bits) increments on each data grant made while an instruction candidate exists.
  - When wait_cnt reaches MAX_WAIT, the instruction wins the next tie.
  - wait_cnt clears on any instruction grant, or when no instruction candidate exists.
- Latency:
  - Zero-wait memory: request c0, mem_request c1, mem_ack c2, cpu ack c3.
  - With both ports requesting in c0, the loser's ack arrives at c5.
- Writes: cpud_rdata is 0 on a write ack. Byte lanes pass through unmodified.
- Widths: cpui_addr is truncated to ADDR_W bits, with no error on the discarded upper bits.

Optional Feature:
- CPU_ARB_STATS_EN.
- Defined: adds two output ports.
  - stat_conflicts, out, 32 bits: counts grants made while both ports had candidates.
  - stat_stall, out, 32 bits: counts cycles where any pending slot is unserved.
  - Both are cleared by reset, wrap at 2^32, and are readable at any time.
- Undefined: neither the ports nor the counter logic exist.

Decomposition:
- Package cpu_arb_pkg holds:
  - arb_state_t enum (IDLE, BUSY_I, BUSY_D);
  - port-id constants PORT_I=0, PORT_D=1;
  - struct arb_req_t {addr, write, byte_enable, wdata}.
- One sub-module, cpu_arb_slot: a pending-request register with capture, clear-on-grant and drop/error detection, instantiated twice.

Test Plan:
- Isolated instruction read: cpui_request, addr 0x0010, memory returns 0xDEADBEEF one cycle after mem_request -> cpui_ack at c3, cpui_rdata=0xDEADBEEF.
- Simultaneous requests in c0: I addr 0x20, D read addr 0x40 -> mem_addr 0x40 first, then 0x20 back-to-back; cpud_ack c3, cpui_ack c5.
- Starvation: a data request every ack plus a pending instruction, MAX_WAIT=4 -> exactly 4 data grants, then the instruction grant; wait_cnt returns to 0.
- Data write: addr 0x100, byte_enable 4'b0011, wdata 0x12345678 -> mem_write=1 with matching fields; cpud_ack with cpud_rdata=0.
- Slow memory with mem_ack 5 cycles late -> one mem_request only, state held; a second cpui_request during wait is dropped and an error is printed.
- Reset asserted in BUSY_D -> outputs 0 immediately; a late mem_ack produces no cpud_ack; a new request after release is served normally.
